// File: rtl/checkpoint_pkg.sv
// Shared constants for the checkpoint sequence monitor: cause bit layout,
// task-count limit and task-index width.
package checkpoint_pkg;

   localparam int MAX_TASKS   = 16;
   localparam int TASK_IDX_W  = 4;

   localparam int CAUSE_W     = 3;
   localparam int CAUSE_TMO   = 0;
   localparam int CAUSE_EARLY = 1;
   localparam int CAUSE_SEQ   = 2;

   // Successor of a task index in a ring of n tasks.
   function automatic logic [TASK_IDX_W-1:0] next_idx(input logic [TASK_IDX_W-1:0] idx,
                                                      input int n);
      return (int'(idx) == n - 1) ? '0 : idx + TASK_IDX_W'(1);
   endfunction

endpackage

// File: rtl/cp_task_wdog.sv
// Per-task watchdog: saturating gap counter cleared on a hit, with
// timeout (gap too long) and early (gap too short) comparisons.
module cp_task_wdog
   import checkpoint_pkg::*;
#(
   parameter int               CNT_W    = 24,
   parameter logic [CNT_W-1:0] TIMEOUT  = '1,
   parameter logic [CNT_W-1:0] MIN_TIME = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic hit_i,
   output logic timeout_o,
   output logic early_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || hit_i)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign timeout_o = (cnt_q > TIMEOUT);
   // A zero minimum disables the early check for this task.
   assign early_o   = hit_i && (MIN_TIME != '0) && (cnt_q < MIN_TIME);

endmodule

// File: rtl/checkpoint_seq_ctrl.sv
// Checkpoint sequence monitor: decodes signature writes into per-task hits,
// runs one watchdog per task and latches sticky alarm/cause/task.
// Optional macro CP_SEQ_CHECK_EN adds task-order (sequence) checking.
module checkpoint_seq_ctrl
   import checkpoint_pkg::*;
#(
   parameter int                       NUM_TASKS      = 4,
   parameter int                       CNT_W          = 24,
   parameter logic [31:0]              SIGNATURE_ADDR = 32'h0007_0000,
   parameter logic [NUM_TASKS*32-1:0]  SIGNATURES     = {32'hCAFEAAA4, 32'hCAFEAAA3,
                                                         32'hCAFEAAA2, 32'hCAFEAAA1},
   parameter logic [NUM_TASKS*CNT_W-1:0] TIMEOUTS     = {24'd9000000, {3{24'd3500000}}},
   parameter logic [NUM_TASKS*CNT_W-1:0] MIN_TIMES    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  checkpoint_valid_i,
   input  logic [31:0]           checkpoint_addr_i,
   input  logic [31:0]           checkpoint_data_i,
   input  logic                  err_clear_i,
   output logic                  cp_error_alarm_o,
   output logic [CAUSE_W-1:0]    err_cause_o,
   output logic [TASK_IDX_W-1:0] err_task_o
);

   logic [NUM_TASKS-1:0]  hit, tmo, early, err_vec;
   logic                  seq_err;
   logic [CAUSE_W-1:0]    cause_now;
   logic [TASK_IDX_W-1:0] err_idx;

   logic                  alarm_q, alarm_d;
   logic [CAUSE_W-1:0]    cause_q, cause_d;
   logic [TASK_IDX_W-1:0] task_q, task_d;

   // Descending scan so duplicate signatures resolve to the lowest task.
   always_comb begin
      hit = '0;
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (checkpoint_valid_i && (checkpoint_addr_i == SIGNATURE_ADDR) &&
             (checkpoint_data_i == SIGNATURES[i*32 +: 32])) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_TASKS; g++) begin : gen_wdog
      cp_task_wdog #(
         .CNT_W    (CNT_W),
         .TIMEOUT  (TIMEOUTS[g*CNT_W +: CNT_W]),
         .MIN_TIME (MIN_TIMES[g*CNT_W +: CNT_W])
      ) u_wdog (
         .clk       (clk),
         .rst       (rst),
         .clear_i   (err_clear_i),
         .hit_i     (hit[g]),
         .timeout_o (tmo[g]),
         .early_o   (early[g])
      );
   end

`ifdef CP_SEQ_CHECK_EN
   logic                  hit_any;
   logic [TASK_IDX_W-1:0] hit_idx;
   logic [TASK_IDX_W-1:0] exp_q, exp_d;

   always_comb begin
      hit_any = |hit;
      hit_idx = '0;
      for (int i = NUM_TASKS - 1; i >= 0; i--)
         if (hit[i]) hit_idx = TASK_IDX_W'(i);
   end

   assign seq_err = hit_any && (hit_idx != exp_q);

   // Expected index resyncs to the successor of whatever task just hit.
   always_comb begin
      exp_d = exp_q;
      if (err_clear_i)  exp_d = '0;
      else if (hit_any) exp_d = next_idx(hit_idx, NUM_TASKS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) exp_q <= '0;
      else     exp_q <= exp_d;
   end
`else
   assign seq_err = 1'b0;
`endif

   assign err_vec = tmo | early | (hit & {NUM_TASKS{seq_err}});

   always_comb begin
      cause_now             = '0;
      cause_now[CAUSE_TMO]   = |tmo;
      cause_now[CAUSE_EARLY] = |early;
      cause_now[CAUSE_SEQ]   = seq_err;
      err_idx = '0;
      for (int i = NUM_TASKS - 1; i >= 0; i--)
         if (err_vec[i]) err_idx = TASK_IDX_W'(i);
   end

   // Clear has priority; err_task_o only captures the first latched error.
   always_comb begin
      alarm_d = alarm_q;
      cause_d = cause_q;
      task_d  = task_q;
      if (err_clear_i) begin
         alarm_d = 1'b1;
         cause_d = '0;
         task_d  = '0;
      end else if (|cause_now) begin
         alarm_d = 1'b0;
         cause_d = cause_q | cause_now;
         if (alarm_q) task_d = err_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_q <= 1'b1;
         cause_q <= '0;
         task_q  <= '0;
      end else begin
         alarm_q <= alarm_d;
         cause_q <= cause_d;
         task_q  <= task_d;
      end
   end

   assign cp_error_alarm_o = alarm_q;
   assign err_cause_o      = cause_q;
   assign err_task_o       = task_q;

endmodule

// File: tb/tb_checkpoint_seq_ctrl.sv
// Randomized scoreboard bench for checkpoint_seq_ctrl with a timestamp-based
// reference model plus directed latency/cause checks.
module tb_checkpoint_seq_ctrl;

   localparam int          N    = 4;
   localparam logic [31:0] ADDR = 32'h0007_0000;
   localparam int          TMO  = 100;
   localparam int          MINT = 10;
`ifdef CP_SEQ_CHECK_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0, valid = 1'b0, clr = 1'b0;
   logic [31:0] addr = '0, data = '0;
   logic        alarm;
   logic [2:0]  cause;
   logic [3:0]  tsk;

   checkpoint_seq_ctrl #(
      .NUM_TASKS      (N),
      .CNT_W          (24),
      .SIGNATURE_ADDR (ADDR),
      .SIGNATURES     ({32'hCAFEAAA4, 32'hCAFEAAA3, 32'hCAFEAAA2, 32'hCAFEAAA1}),
      .TIMEOUTS       ({4{24'd100}}),
      .MIN_TIMES      ({4{24'd10}})
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .checkpoint_valid_i (valid),
      .checkpoint_addr_i  (addr),
      .checkpoint_data_i  (data),
      .err_clear_i        (clr),
      .cp_error_alarm_o   (alarm),
      .err_cause_o        (cause),
      .err_task_o         (tsk)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       a;
      logic [2:0] c;
      logic [3:0] t;
   } exp_t;

   exp_t        sb[$];
   int          vec = 0, miss = 0;
   logic [31:0] sig [N];

   // Model state: edge count since reset and edge of each task's last restart.
   int         e;
   int         last [N];
   bit         m_alarm;
   logic [2:0] m_cause;
   int         m_task;
   int         m_exp;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      e = 0;
      for (int i = 0; i < N; i++) last[i] = 0;
      m_alarm = 1'b1; m_cause = '0; m_task = 0; m_exp = 0;
   endfunction

   // One bus cycle: drive inputs, advance the model, queue the expected outputs.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic c);
      int h, cur, first;
      logic [2:0] cn;
      exp_t x;
      @(negedge clk);
      valid = v; addr = a; data = d; clr = c;
      h = -1;
      if (v && a == ADDR)
         for (int i = N - 1; i >= 0; i--) if (d == sig[i]) h = i;
      cn = '0; first = -1;
      for (int i = N - 1; i >= 0; i--) begin
         cur = e - last[i];
         if (cur > TMO) begin cn[0] = 1'b1; first = i; end
         if (i == h && cur < MINT) begin cn[1] = 1'b1; first = i; end
         if (SEQ_EN && i == h && h != m_exp) begin cn[2] = 1'b1; first = i; end
      end
      if (c) begin
         m_alarm = 1'b1; m_cause = '0; m_task = 0; m_exp = 0;
         for (int i = 0; i < N; i++) last[i] = e + 1;
      end else begin
         if (cn != 0) begin
            if (m_alarm) m_task = first;
            m_alarm = 1'b0;
            m_cause = m_cause | cn;
         end
         if (h >= 0) begin
            last[h] = e + 1;
            m_exp   = (h + 1) % N;
         end
      end
      e++;
      x.a = m_alarm; x.c = m_cause; x.t = 4'(m_task);
      sb.push_back(x);
   endtask

   // Non-hit traffic: idle bus, valid=0 with a real signature, unknown data,
   // or a real signature at the wrong address.
   task automatic idle();
      case ($urandom_range(0, 3))
         0:       step(1'b0, 32'h0, 32'h0, 1'b0);
         1:       step(1'b0, ADDR, sig[$urandom_range(0, N-1)], 1'b0);
         2:       step(1'b1, ADDR, {16'h1234, 16'($urandom)}, 1'b0);
         default: step(1'b1, ADDR + 32'h4, sig[$urandom_range(0, N-1)], 1'b0);
      endcase
   endtask

   task automatic hit_task(input int i, input int gap);
      repeat (gap - 1) idle();
      step(1'b1, ADDR, sig[i], 1'b0);
   endtask

   task automatic observe();
      @(posedge clk);
      #2;
   endtask

   // Idle until the alarm drops; returns edges elapsed since ref_edge, or -1.
   task automatic wait_alarm(input int ref_edge, output int got);
      got = -1;
      for (int k = 0; k < 300; k++) begin
         idle();
         observe();
         if (!alarm) begin got = e - ref_edge; break; end
      end
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (!rst && sb.size() > 0) begin
         x = sb.pop_front();
         chk("scoreboard{alarm,cause,task}", {alarm, cause, tsk}, {x.a, x.c, x.t});
      end
   end

   initial begin
      int t2, got;
      sig[0] = 32'hCAFEAAA1; sig[1] = 32'hCAFEAAA2;
      sig[2] = 32'hCAFEAAA3; sig[3] = 32'hCAFEAAA4;
      model_reset();

      #1 rst = 1'b1;
      #1;
      chk("reset_alarm", alarm, 1'b1);
      chk("reset_cause", cause, 3'b000);
      chk("reset_task", tsk, 4'd0);
      @(posedge clk); #3 rst = 1'b0;

      // Healthy rounds: each task every 20 cycles, noise in between.
      repeat (12) idle();
      for (int k = 0; k < 1000; k++) begin
         if (k % 5 == 0) step(1'b1, ADDR, sig[(k % 20) / 5], 1'b0);
         else            idle();
      end
      observe();
      chk("healthy_alarm", alarm, 1'b1);
      chk("healthy_cause", cause, 3'b000);

      // Task 2 goes silent; others keep their slot for one more round.
      step(1'b1, ADDR, sig[0], 1'b0);
      repeat (4) idle();
      step(1'b1, ADDR, sig[1], 1'b0);
      repeat (4) idle();
      step(1'b1, ADDR, sig[2], 1'b0);
      t2 = e;
      got = -1;
      for (int k = 1; k <= 300; k++) begin
         if      (k == 5)  step(1'b1, ADDR, sig[3], 1'b0);
         else if (k == 10) step(1'b1, ADDR, sig[0], 1'b0);
         else if (k == 15) step(1'b1, ADDR, sig[1], 1'b0);
         else              idle();
         observe();
         if (!alarm) begin got = e - t2; break; end
      end
      chk("timeout_latency", got, 102);
      chk("timeout_cause", cause, 3'b001);
      chk("timeout_task", tsk, 4'd2);

      // Early: task 1 re-hits 5 cycles after its previous hit, in order.
      step(1'b0, 32'h0, 32'h0, 1'b1);
      hit_task(0, 12); hit_task(1, 12); hit_task(2, 12); hit_task(3, 12);
      hit_task(0, 12); hit_task(1, 12); hit_task(2, 1);  hit_task(3, 1);
      hit_task(0, 1);
      observe();
      chk("pre_early_alarm", alarm, 1'b1);
      hit_task(1, 2);
      observe();
      chk("early_alarm", alarm, 1'b0);
      chk("early_cause", cause, 3'b010);
      chk("early_task", tsk, 4'd1);

      // Out-of-order hit, then resync to the successor.
      step(1'b0, 32'h0, 32'h0, 1'b1);
      hit_task(0, 12); hit_task(2, 12);
      observe();
      chk("seq_cause", cause, SEQ_EN ? 3'b100 : 3'b000);
      chk("seq_task", tsk, SEQ_EN ? 4'd2 : 4'd0);
      hit_task(3, 12);
      observe();
      chk("seq_resync_cause", cause, SEQ_EN ? 3'b100 : 3'b000);

      // Clear coinciding with the cycle a timeout would latch.
      step(1'b0, 32'h0, 32'h0, 1'b1);
      repeat (101) idle();
      step(1'b0, 32'h0, 32'h0, 1'b1);
      t2 = e;
      observe();
      chk("clear_vs_tmo_alarm", alarm, 1'b1);
      chk("clear_vs_tmo_cause", cause, 3'b000);
      wait_alarm(t2, got);
      chk("restart_latency", got, 102);

      // Random traffic with occasional clears.
      for (int k = 0; k < 600; k++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2)       step(1'b0, 32'h0, 32'h0, 1'b1);
         else if (r < 35) step(1'b1, ADDR, sig[$urandom_range(0, N-1)], 1'b0);
         else             idle();
      end

      // Asynchronous reset while the alarm is low.
      repeat (110) idle();
      observe();
      chk("pre_reset_alarm", alarm, 1'b0);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("async_reset_alarm", alarm, 1'b1);
      chk("async_reset_cause", cause, 3'b000);
      chk("async_reset_task", tsk, 4'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      repeat (12) idle();
      for (int k = 0; k < 80; k++) begin
         if (k % 5 == 0) step(1'b1, ADDR, sig[(k % 20) / 5], 1'b0);
         else            idle();
      end
      observe();
      chk("post_reset_alarm", alarm, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
